// File: rtl/bcd_counter_n.sv
// bcd_counter_n: parametrised multi-digit packed BCD counter with enable, sync clear, parallel load
//   Optional feature macro: BCD_UPDOWN_EN adds the dir port and down counting.
//   Parameters: DIGITS  number of BCD digits (1..8), digit 0 is the LS nibble
//   Ports:
//     clk       rising-edge system clock
//     reset     asynchronous active-high reset (count and c_out to zero)
//     en        count enable, one step per edge
//     clr       synchronous clear, overrides load and en
//     load      synchronous parallel load of load_val, overrides en
//     load_val  packed BCD load value; nibbles above 9 load as 0
//     dir       0 = up, 1 = down (only with BCD_UPDOWN_EN)
//     count     registered packed BCD count
//     c_out     registered one-cycle wrap (carry/borrow) pulse
//     tc        combinational: en high and the next step wraps
module bcd_counter_n #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
`ifdef BCD_UPDOWN_EN
    input  logic                  dir,
`endif
    output logic [4*DIGITS-1:0]   count,
    output logic                  c_out,
    output logic                  tc
);
    logic                down;
    logic [4*DIGITS-1:0] nxt;
    logic [4*DIGITS-1:0] ld_fix;
    logic                carry;
    logic [3:0]          d;

`ifdef BCD_UPDOWN_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif

    // Ripple the step through the digits; carry ends high only when every digit was terminal.
    always_comb begin
        nxt    = count;
        ld_fix = load_val;
        carry  = 1'b1;
        d      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            if (carry)
                nxt[4*i +: 4] = down ? ((d == 4'd0) ? 4'd9 : d - 4'd1)
                                     : ((d == 4'd9) ? 4'd0 : d + 4'd1);
            carry = carry & (down ? (d == 4'd0) : (d == 4'd9));
            ld_fix[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
        end
    end

    assign tc = en & carry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            c_out <= 1'b0;
        end else if (clr) begin
            count <= '0;
            c_out <= 1'b0;
        end else if (load) begin
            count <= ld_fix;
            c_out <= 1'b0;
        end else if (en) begin
            count <= nxt;
            c_out <= carry;
        end else begin
            c_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: self-checking bench for bcd_counter_n (2- and 4-digit instances, shared controls)
module tb_bcd_counter_n;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b0;
    logic [15:0] lv4 = '0;
    logic [7:0]  lv2;
    logic [7:0]  count2;
    logic [15:0] count4;
    logic        co2, co4, tc2, tc4;
    int          n_cmp = 0, n_err = 0;
    int          mv[2] = '{0, 0};
    bit          mc[2] = '{0, 0};
    int          mm[2] = '{100, 10000};
    int          nd[2] = '{2, 4};

    assign lv2 = lv4[7:0];

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .load_val(lv2),
`ifdef BCD_UPDOWN_EN
        .dir(dir),
`endif
        .count(count2), .c_out(co2), .tc(tc2));

    bcd_counter_n #(.DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .load_val(lv4),
`ifdef BCD_UPDOWN_EN
        .dir(dir),
`endif
        .count(count4), .c_out(co4), .tc(tc4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] int2bcd(input int v);
        logic [31:0] r = '0;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int bcd2int(input logic [31:0] b, input int n);
        int s = 0;
        for (int k = n - 1; k >= 0; k--)
            s = s * 10 + ((b[4*k +: 4] > 4'd9) ? 0 : int'(b[4*k +: 4]));
        return s;
    endfunction

    function automatic bit down_now();
`ifdef BCD_UPDOWN_EN
        return dir;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: check tc against the pre-edge model, advance the model, check registered outputs.
    task automatic tick();
        bit dn;
        #1;
        dn = down_now();
        check("tc2", {31'b0, tc2}, {31'b0, en && (dn ? mv[0] == 0 : mv[0] == mm[0] - 1)});
        check("tc4", {31'b0, tc4}, {31'b0, en && (dn ? mv[1] == 0 : mv[1] == mm[1] - 1)});
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                mv[i] = 0; mc[i] = 0;
            end else if (load) begin
                mv[i] = bcd2int({16'b0, lv4}, nd[i]); mc[i] = 0;
            end else if (en) begin
                mc[i] = dn ? (mv[i] == 0) : (mv[i] == mm[i] - 1);
                mv[i] = dn ? (mv[i] + mm[i] - 1) % mm[i] : (mv[i] + 1) % mm[i];
            end else begin
                mc[i] = 0;
            end
        end
        @(posedge clk);
        #1;
        check("count2", {24'b0, count2}, int2bcd(mv[0]));
        check("count4", {16'b0, count4}, int2bcd(mv[1]));
        check("c_out2", {31'b0, co2}, {31'b0, mc[0]});
        check("c_out4", {31'b0, co4}, {31'b0, mc[1]});
    endtask

    task automatic set_in(input bit e, input bit c, input bit l, input logic [15:0] v);
        en = e; clr = c; load = l; lv4 = v;
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear before the next edge.
    task automatic async_reset();
        #3 reset = 1'b1;
        #1;
        check("rst_count2", {24'b0, count2}, 32'h0);
        check("rst_count4", {16'b0, count4}, 32'h0);
        check("rst_c_out2", {31'b0, co2}, 32'h0);
        check("rst_c_out4", {31'b0, co4}, 32'h0);
        #1 reset = 1'b0;
        mv = '{0, 0};
        mc = '{0, 0};
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("init_count2", {24'b0, count2}, 32'h0);
        check("init_c_out2", {31'b0, co2}, 32'h0);
        reset = 1'b0;
        // Full up-count through wrap on the 2-digit instance.
        set_in(1, 0, 0, 16'h0);
        for (int i = 0; i < 100; i++) tick();
        check("wrap_count2", {24'b0, count2}, 32'h0);
        check("wrap_c_out2", {31'b0, co2}, 32'h1);
        set_in(0, 0, 0, 16'h0);
        tick();
        // Invalid nibble loads as 0; load beats en.
        set_in(0, 0, 1, 16'h00A7);
        tick();
        check("load_fix", {24'b0, count2}, 32'h07);
        set_in(1, 0, 1, 16'h0098);
        tick();
        check("load_wins", {24'b0, count2}, 32'h98);
        // Clear beats load and en, then en toggled every cycle.
        set_in(0, 0, 1, 16'h0055);
        tick();
        set_in(1, 1, 1, 16'h0055);
        tick();
        check("clr_wins", {24'b0, count2}, 32'h00);
        for (int i = 0; i < 10; i++) begin
            set_in(i % 2 == 0, 0, 0, 16'h0);
            tick();
        end
        check("toggle", {24'b0, count2}, 32'h05);
        // Reset mid-count from 0x37.
        set_in(0, 0, 1, 16'h0037);
        tick();
        set_in(1, 0, 0, 16'h0);
        async_reset();
        tick();
        // Four-digit wrap from 0x9999.
        set_in(0, 0, 1, 16'h9999);
        tick();
        set_in(1, 0, 0, 16'h0);
        tick();
        check("wrap_count4", {16'b0, count4}, 32'h0);
        check("wrap_c_out4", {31'b0, co4}, 32'h1);
        set_in(0, 0, 0, 16'h0);
        tick();
`ifdef BCD_UPDOWN_EN
        set_in(0, 0, 1, 16'h0001);
        tick();
        dir = 1'b1;
        set_in(1, 0, 0, 16'h0);
        tick();
        tick();
        check("borrow_count2", {24'b0, count2}, 32'h99);
        check("borrow_c_out2", {31'b0, co2}, 32'h1);
        dir = 1'b0;
        tick();
        check("up_after_down", {24'b0, count2}, 32'h00);
        check("carry_after_down", {31'b0, co2}, 32'h1);
`endif
        // Random mix, including invalid load nibbles and occasional async resets.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(9, 0) < 7, $urandom_range(19, 0) == 0,
                   $urandom_range(9, 0) == 0, 16'($urandom));
`ifdef BCD_UPDOWN_EN
            dir = $urandom_range(3, 0) == 0;
`endif
            if ($urandom_range(199, 0) == 0) async_reset();
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
